// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Debounces N_BTN raw pushbutton pins. Each pin is polarity-corrected,
//   synchronised into the clk domain, then sampled on a shared slow tick.
//   A change is accepted only after STABLE_CNT consecutive ticks disagree
//   with the current debounced level. Once a press is accepted, a per-button
//   counter measures how long it is held and raises a single long-press event.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   btn_raw      asynchronous button pins (N_BTN)
//   btn_level    debounced level, 1 = pressed
//   btn_press    1-cycle pulse on accepted 0->1
//   btn_release  1-cycle pulse on accepted 1->0
//   btn_long     1-cycle pulse once a press has been held LONG_CNT ticks
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 250_000,
    parameter int STABLE_CNT = 4,
    parameter int LONG_CNT   = 100,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int LW = $clog2(LONG_CNT + 1);

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CNT - 1);
    localparam logic [LW-1:0] LONG_MAX    = LW'(LONG_CNT);
    localparam logic [LW-1:0] LONG_LAST   = LW'(LONG_CNT - 1);

    logic [N_BTN-1:0] pin_s;
    logic [N_BTN-1:0] sync1_r;
    logic [N_BTN-1:0] sync2_r;
    logic [TW-1:0]    tick_cnt_r;
    logic             tick_s;

    logic [N_BTN-1:0] level_r;
    logic [N_BTN-1:0] press_r;
    logic [N_BTN-1:0] release_r;
    logic [N_BTN-1:0] long_r;
    logic [CW-1:0]    cnt_r  [N_BTN];
    logic [LW-1:0]    lc_r   [N_BTN];

    logic [N_BTN-1:0] level_nxt_s;
    logic [N_BTN-1:0] press_nxt_s;
    logic [N_BTN-1:0] release_nxt_s;
    logic [N_BTN-1:0] long_nxt_s;
    logic [CW-1:0]    cnt_nxt_s [N_BTN];
    logic [LW-1:0]    lc_nxt_s  [N_BTN];

    // Polarity correction so everything downstream sees 1 = pressed
    always_comb begin
        if (ACTIVE_LOW) begin
            pin_s = ~btn_raw;
        end else begin
            pin_s = btn_raw;
        end
    end

    // Two-flop synchroniser; reset value is "not pressed"
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= pin_s;
            sync2_r <= sync1_r;
        end
    end

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Shared sample-tick divider, 0..TICK_DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Per-button stability and long-press next-state logic
    always_comb begin
        level_nxt_s   = level_r;
        press_nxt_s   = '0;
        release_nxt_s = '0;
        long_nxt_s    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            lc_nxt_s[i]  = lc_r[i];

            if (tick_s) begin
                if (sync2_r[i] == level_r[i]) begin
                    cnt_nxt_s[i] = '0;
                end else if (cnt_r[i] == STABLE_LAST) begin
                    cnt_nxt_s[i]     = '0;
                    level_nxt_s[i]   = sync2_r[i];
                    press_nxt_s[i]   = sync2_r[i];
                    release_nxt_s[i] = ~sync2_r[i];
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CW'(1);
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end

            // Hold time only accumulates while the press is stable; a tick that
            // accepts a release ends the press instead of counting toward long.
            if (!level_r[i] || press_nxt_s[i]) begin
                lc_nxt_s[i] = '0;
            end else if (tick_s && !release_nxt_s[i] && (lc_r[i] != LONG_MAX)) begin
                lc_nxt_s[i]   = lc_r[i] + LW'(1);
                long_nxt_s[i] = (lc_r[i] == LONG_LAST);
            end else begin
                lc_nxt_s[i] = lc_r[i];
            end
        end
    end

    // Registered level, pulses and per-button counters
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r   <= '0;
            press_r   <= '0;
            release_r <= '0;
            long_r    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_r[i] <= '0;
                lc_r[i]  <= '0;
            end
        end else begin
            level_r   <= level_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            long_r    <= long_nxt_s;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
                lc_r[i]  <= lc_nxt_s[i];
            end
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;
    assign btn_long    = long_r;

endmodule
